// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel enable, free-running x/y, registered syncs, video_on decode.
// x/y/hsync/vsync update together on the p_tick edge; video_on is combinational; no backpressure.
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             hsync_next;
    logic             vsync_next;

    // Decoded from the divider register so the enable can never stretch.
    assign p_tick = (div == DIV_LAST);

    always_comb begin
        x_next = x;
        y_next = y;
        if (x == H_LAST) begin
            x_next = '0;
            y_next = (y == V_LAST) ? '0 : y + 10'd1;
        end else begin
            x_next = x + 10'd1;
        end
    end

    // Syncs are computed from the next counts so they land on the same edge as x/y.
    assign hsync_next = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
    assign vsync_next = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div   <= '0;
            x     <= '0;
            y     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            div <= p_tick ? '0 : div + 1'b1;
            if (p_tick) begin
                x     <= x_next;
                y     <= y_next;
                hsync <= hsync_next;
                vsync <= vsync_next;
            end
        end
    end

    assign video_on = (x < H_VIS) && (y < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing instance for reset/line/mid-frame checks, plus a
// shrunken-parameter instance so vertical timing and frame wrap fit in a short run.
module tb_vga_sync_gen;

    logic clk;
    logic reset;

    logic       d_p_tick, d_video_on, d_hsync, d_vsync;
    logic [9:0] d_x, d_y;
    logic       s_p_tick, s_video_on, s_hsync, s_vsync;
    logic [9:0] s_x, s_y;

    int checks   = 0;
    int failures = 0;
    int n;

    // Per-signal trace mismatch counters: x, y, p_tick, hsync, vsync, video_on.
    int err_d[6];
    int err_s[6];
    int d_hs_low, d_vo_fall_n, d_y1_n, d_tick_cnt;
    int s_vs_low, s_fall1, s_fall2, s_consumer;
    int s_x329, s_y329, s_p329, s_x330, s_y330;
    logic d_vo_prev, s_vs_prev;

    vga_sync_gen d (
        .clk(clk), .reset(reset), .p_tick(d_p_tick), .x(d_x), .y(d_y),
        .video_on(d_video_on), .hsync(d_hsync), .vsync(d_vsync)
    );

    // H_TOTAL = 15, V_TOTAL = 11, 2 clk per pixel -> 330 clk per frame.
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) s (
        .clk(clk), .reset(reset), .p_tick(s_p_tick), .x(s_x), .y(s_y),
        .video_on(s_video_on), .hsync(s_hsync), .vsync(s_vsync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            err_d[i] = 0;
            err_s[i] = 0;
        end
        d_hs_low = 0; d_vo_fall_n = -1; d_y1_n = -1; d_tick_cnt = 0;
        s_vs_low = 0; s_fall1 = -1; s_fall2 = -1; s_consumer = 0;
        s_x329 = -1; s_y329 = -1; s_p329 = -1; s_x330 = -1; s_y330 = -1;
        d_vo_prev = 1'b1;
        s_vs_prev = 1'b1;
    endtask

    // n counts negedges since reset release; expected values follow from n directly.
    task automatic run(input int cycles);
        int xe, ye;
        logic pe, he, ve, voe;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n++;
            xe  = (n / 4) % 800;
            ye  = (n / 3200) % 525;
            pe  = (n % 4) == 3;
            he  = !(xe >= 656 && xe <= 751);
            ve  = !(ye >= 490 && ye <= 491);
            voe = (xe < 640) && (ye < 480);
            if (d_x !== 10'(xe))      err_d[0]++;
            if (d_y !== 10'(ye))      err_d[1]++;
            if (d_p_tick !== pe)      err_d[2]++;
            if (d_hsync !== he)       err_d[3]++;
            if (d_vsync !== ve)       err_d[4]++;
            if (d_video_on !== voe)   err_d[5]++;
            if (n <= 3200 && d_hsync === 1'b0) d_hs_low++;
            if (n <= 400 && d_p_tick === 1'b1) d_tick_cnt++;
            if (d_vo_fall_n < 0 && d_vo_prev === 1'b1 && d_video_on === 1'b0) d_vo_fall_n = n;
            if (d_y1_n < 0 && d_y === 10'd1) d_y1_n = n;
            d_vo_prev = d_video_on;

            xe  = (n / 2) % 15;
            ye  = (n / 30) % 11;
            pe  = (n % 2) == 1;
            he  = !(xe >= 10 && xe <= 12);
            ve  = !(ye >= 7 && ye <= 8);
            voe = (xe < 8) && (ye < 6);
            if (s_x !== 10'(xe))      err_s[0]++;
            if (s_y !== 10'(ye))      err_s[1]++;
            if (s_p_tick !== pe)      err_s[2]++;
            if (s_hsync !== he)       err_s[3]++;
            if (s_vsync !== ve)       err_s[4]++;
            if (s_video_on !== voe)   err_s[5]++;
            if (n <= 330 && s_vsync === 1'b0) s_vs_low++;
            if (n <= 660 && s_y === 10'd7 && s_x === 10'd0 && s_p_tick === 1'b1) s_consumer++;
            if (s_vs_prev === 1'b1 && s_vsync === 1'b0) begin
                if (s_fall1 < 0) s_fall1 = n;
                else if (s_fall2 < 0) s_fall2 = n;
            end
            s_vs_prev = s_vsync;
            if (n == 329) begin s_x329 = int'(s_x); s_y329 = int'(s_y); s_p329 = int'(s_p_tick); end
            if (n == 330) begin s_x330 = int'(s_x); s_y330 = int'(s_y); end
        end
    endtask

    task automatic check_run(input string ph);
        chk({ph, "_d_x_trace"},      err_d[0], 0);
        chk({ph, "_d_y_trace"},      err_d[1], 0);
        chk({ph, "_d_ptick_trace"},  err_d[2], 0);
        chk({ph, "_d_hsync_trace"},  err_d[3], 0);
        chk({ph, "_d_vsync_trace"},  err_d[4], 0);
        chk({ph, "_d_vidon_trace"},  err_d[5], 0);
        chk({ph, "_s_x_trace"},      err_s[0], 0);
        chk({ph, "_s_y_trace"},      err_s[1], 0);
        chk({ph, "_s_ptick_trace"},  err_s[2], 0);
        chk({ph, "_s_hsync_trace"},  err_s[3], 0);
        chk({ph, "_s_vsync_trace"},  err_s[4], 0);
        chk({ph, "_s_vidon_trace"},  err_s[5], 0);
        chk({ph, "_hsync_low_clks"}, d_hs_low, 384);
        chk({ph, "_ptick_in_400"},   d_tick_cnt, 100);
        chk({ph, "_vidon_fall_n"},   d_vo_fall_n, 2560);
        chk({ph, "_y_step_n"},       d_y1_n, 3200);
        chk({ph, "_s_vsync_low"},    s_vs_low, 60);
        chk({ph, "_s_vs_fall1"},     s_fall1, 210);
        chk({ph, "_s_vs_period"},    s_fall2 - s_fall1, 330);
        chk({ph, "_s_consumer"},     s_consumer, 2);
        chk({ph, "_s_x_before_wrap"}, s_x329, 14);
        chk({ph, "_s_y_before_wrap"}, s_y329, 10);
        chk({ph, "_s_p_before_wrap"}, s_p329, 1);
        chk({ph, "_s_x_after_wrap"},  s_x330, 0);
        chk({ph, "_s_y_after_wrap"},  s_y330, 0);
    endtask

    initial begin
        reset = 1'b0;
        clear_stats();
        repeat (10) @(negedge clk);
        chk("rst_x",      d_x, 0);
        chk("rst_y",      d_y, 0);
        chk("rst_hsync",  d_hsync, 1);
        chk("rst_vsync",  d_vsync, 1);
        chk("rst_vidon",  d_video_on, 1);
        chk("rst_ptick",  d_p_tick, 0);
        chk("rst_s_ptick", s_p_tick, 0);
        chk("rst_s_x",    s_x, 0);

        reset = 1'b1;
        run(7602);
        check_run("p1");
        chk("pre_mid_x",     d_x, 300);
        chk("pre_mid_y",     d_y, 2);

        // Assert reset between edges, right after the edge that raised p_tick.
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_x",     d_x, 0);
        chk("mid_y",     d_y, 0);
        chk("mid_ptick", d_p_tick, 0);
        chk("mid_hsync", d_hsync, 1);
        chk("mid_vsync", d_vsync, 1);
        chk("mid_vidon", d_video_on, 1);
        chk("mid_s_x",   s_x, 0);

        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        run(3400);
        check_run("p2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
